// File: rtl/rf_arb_pkg.sv
// Shared types and helpers for the register-file write arbiter.
//   arb_state_e : arbiter FSM state (free arbitration / locked burst owner)
//   rr_pick_t   : result of a round-robin search (found flag + index)
//   src_w()     : index width for a given requester count
//   rr_pick()   : first valid requester at or after ptr, wrapping modulo n
package rf_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned IDX_W   = 3;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned src_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Rotating priority search; ptr < n is assumed, so a single subtract wraps.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [IDX_W-1:0]   ptr,
                                         input int unsigned        n);
        rr_pick_t    p;
        int unsigned i;
        p = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                i = 32'(ptr) + k;
                if (i >= n) begin
                    i = i - n;
                end
                if (!p.found && valid[IDX_W'(i)]) begin
                    p.found = 1'b1;
                    p.idx   = IDX_W'(i);
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_rr.sv
// Combinational round-robin arbiter.
//   valid : per-requester request
//   ptr   : index holding highest priority this cycle
//   grant : one-hot grant (all zero when nothing is valid)
//   idx   : binary index of the granted requester
//   found : at least one requester is valid
module rr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned SRC_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [SRC_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [SRC_W-1:0]   idx,
    output logic               found
);

    rr_pick_t pick;

    // Rotate priority from ptr and expand the winner to one-hot.
    always_comb begin
        pick  = rr_pick(MAX_REQ'(valid), IDX_W'(ptr), NUM_REQ);
        found = pick.found;
        idx   = SRC_W'(pick.idx);
        grant = '0;
        if (pick.found) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the single write port of the vector register bank among NUM_REQ
// writers with round-robin arbitration and optional burst locking.
//   clk, reset          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester valid/ready handshake
//   req_lock            : hold the grant after this beat (multi-beat burst)
//   req_addr/req_data   : packed per-requester address/data, i at [i*W +: W]
//   wr_en/addr/data/src : registered single-entry write beat to the bank
//   wr_ready            : bank consumes the wr_* beat this cycle
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 16,
    localparam int unsigned SRC_W  = src_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic [SRC_W-1:0]          wr_src,
    input  logic                      wr_ready
);

    arb_state_e         state;
    logic [SRC_W-1:0]   ptr;
    logic [SRC_W-1:0]   owner;

    logic [NUM_REQ-1:0] arb_grant;
    logic [SRC_W-1:0]   arb_idx;
    logic               arb_found;

    logic               free;
    logic               accept;
    logic [SRC_W-1:0]   sel;
    logic               sel_lock;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .SRC_W   (SRC_W)
    ) u_rr (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .found (arb_found)
    );

    // Output stage can take a new beat when empty or being drained now.
    assign free = !wr_en || wr_ready;

    // Ready depends only on control state and valids; forced low in reset.
    always_comb begin
        req_ready = '0;
        sel       = arb_idx;
        if (reset) begin
            if (state == LOCK) begin
                // Owner keeps the port even while idle; everyone else waits.
                sel              = owner;
                req_ready[owner] = free;
            end else if (arb_found) begin
                req_ready = arb_grant & {NUM_REQ{free}};
            end
        end
    end

    assign accept   = |(req_valid & req_ready);
    assign sel_lock = req_lock[sel];

    // Payload mux for the selected requester.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (sel == SRC_W'(i)) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // FSM, rotation pointer, burst owner and the registered write beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ARB;
            ptr     <= '0;
            owner   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_src  <= '0;
        end else if (accept) begin
            wr_en   <= 1'b1;
            wr_addr <= sel_addr;
            wr_data <= sel_data;
            wr_src  <= sel;
            owner   <= sel;
            ptr     <= (sel == SRC_W'(NUM_REQ - 1)) ? '0 : sel + SRC_W'(1);
            state   <= sel_lock ? LOCK : ARB;
        end else if (free) begin
            // Address and data hold; only the strobe drops.
            wr_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus
// randomized traffic compared against a behavioural arbitration model.
module tb_rf_write_arbiter;

    localparam int N = 3;

    logic          clk;
    logic          reset;
    logic [2:0]    req_valid;
    logic [2:0]    req_lock;
    logic [11:0]   req_addr;
    logic [47:0]   req_data;
    logic [2:0]    req_ready;
    logic          wr_en;
    logic [3:0]    wr_addr;
    logic [15:0]   wr_data;
    logic [1:0]    wr_src;
    logic          wr_ready;

    rf_write_arbiter #(
        .NUM_REQ (3),
        .ADDR_W  (4),
        .DATA_W  (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_src    (wr_src),
        .wr_ready  (wr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus held by the bench for each requester
    bit          v_valid [N];
    bit          v_lock  [N];
    logic [3:0]  v_addr  [N];
    logic [15:0] v_data  [N];
    bit          v_wready;

    // Reference model state
    int          m_ptr;
    int          m_own;
    bit          m_lk;
    bit          m_en;
    logic [3:0]  m_addr;
    logic [15:0] m_data;
    int          m_src;

    int          checks;
    int          errors;
    logic [2:0]  obs_ready;
    int          last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_ptr  = 0;
        m_own  = 0;
        m_lk   = 0;
        m_en   = 0;
        m_addr = '0;
        m_data = '0;
        m_src  = 0;
    endfunction

    // Which requester may hand over a beat this cycle.
    function automatic logic [2:0] model_ready();
        logic [2:0] r;
        bit         free;
        bit         found;
        int         i;
        r     = '0;
        free  = !m_en || v_wready;
        found = 0;
        if (m_lk) begin
            r[m_own] = free;
        end else begin
            for (int k = 0; k < N; k++) begin
                i = (m_ptr + k) % N;
                if (!found && v_valid[i]) begin
                    found = 1;
                    r[i]  = free;
                end
            end
        end
        return r;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = v_valid[i];
            req_lock[i]           = v_lock[i];
            req_addr[i*4 +: 4]    = v_addr[i];
            req_data[i*16 +: 16]  = v_data[i];
        end
        wr_ready = v_wready;
    endtask

    // One clock: check ready, clock, update model, check write beat.
    task automatic cycle();
        logic [2:0] exp;
        drive();
        #1;
        exp       = model_ready();
        obs_ready = req_ready;
        chk("req_ready", 32'(req_ready), 32'(exp));
        last_acc = -1;
        for (int i = 0; i < N; i++) begin
            if (v_valid[i] && exp[i]) last_acc = i;
        end
        @(posedge clk);
        if (last_acc >= 0) begin
            m_en   = 1;
            m_addr = v_addr[last_acc];
            m_data = v_data[last_acc];
            m_src  = last_acc;
            m_ptr  = (last_acc + 1) % N;
            m_lk   = v_lock[last_acc];
            m_own  = last_acc;
        end else if (!m_en || v_wready) begin
            m_en = 0;
        end
        #1;
        chk("wr_en",   32'(wr_en),   32'(m_en));
        chk("wr_src",  32'(wr_src),  32'(m_src));
        chk("wr_addr", 32'(wr_addr), 32'(m_addr));
        chk("wr_data", 32'(wr_data), 32'(m_data));
    endtask

    task automatic clr();
        for (int i = 0; i < N; i++) begin
            v_valid[i] = 0;
            v_lock[i]  = 0;
        end
    endtask

    task automatic all_valid();
        for (int i = 0; i < N; i++) begin
            v_valid[i] = 1;
            v_lock[i]  = 0;
            v_addr[i]  = 4'(i + 8);
            v_data[i]  = 16'h1000 + 16'(i);
        end
    endtask

    // Asynchronous reset mid-cycle with requests pending; release one edge later.
    task automatic do_reset();
        for (int i = 0; i < N; i++) v_valid[i] = 1;
        v_wready = 1;
        drive();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_wr_en",     32'(wr_en),     32'(0));
        chk("rst_wr_addr",   32'(wr_addr),   32'(0));
        chk("rst_wr_data",   32'(wr_data),   32'(0));
        chk("rst_wr_src",    32'(wr_src),    32'(0));
        chk("rst_req_ready", 32'(req_ready), 32'(0));
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_req_ready_hold", 32'(req_ready), 32'(0));
        reset = 1'b1;
        clr();
    endtask

    task automatic regen(input int i);
        v_valid[i] = ($urandom % 10) < 6;
        v_lock[i]  = ($urandom % 10) < 3;
        v_addr[i]  = 4'($urandom);
        v_data[i]  = 16'($urandom);
    endtask

    // Random traffic; unaccepted beats are held by their requester.
    task automatic rand_cycles(input int n);
        for (int i = 0; i < N; i++) regen(i);
        for (int c = 0; c < n; c++) begin
            v_wready = ($urandom % 10) < 7;
            cycle();
            for (int i = 0; i < N; i++) begin
                if (!(v_valid[i] && last_acc != i)) regen(i);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        req_valid = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_data  = '0;
        wr_ready  = 1'b0;
        clr();
        for (int i = 0; i < N; i++) begin
            v_addr[i] = '0;
            v_data[i] = '0;
        end
        model_reset();
        do_reset();

        rand_cycles(200);

        // Reset mid-run, then a single beat from requester 1
        do_reset();
        v_valid[1] = 1; v_addr[1] = 4'd5; v_data[1] = 16'hA5A5; v_wready = 1;
        cycle();
        chk("t1_en",   32'(wr_en),   32'(1));
        chk("t1_addr", 32'(wr_addr), 32'(5));
        chk("t1_data", 32'(wr_data), 32'hA5A5);
        chk("t1_src",  32'(wr_src),  32'(1));

        // All valid: strict rotation, one beat per cycle
        do_reset();
        all_valid();
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("t2_src", 32'(wr_src), 32'(k % 3));
            chk("t2_en",  32'(wr_en),  32'(1));
        end

        // Four-beat locked burst from requester 2 with 0 and 1 waiting
        do_reset();
        v_valid[1] = 1; v_addr[1] = 4'd1; v_data[1] = 16'h0001;
        cycle();
        chk("t3_setup_src", 32'(wr_src), 32'(1));
        all_valid();
        for (int k = 0; k < 6; k++) begin
            v_lock[2] = (k < 3);
            cycle();
            chk("t3_src", 32'(wr_src), 32'((k < 4) ? 2 : (k == 4 ? 0 : 1)));
        end

        // Bank backpressure for three cycles, then back-to-back resume
        do_reset();
        all_valid();
        cycle();
        chk("t4_first_src", 32'(wr_src), 32'(0));
        v_wready = 0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t4_hold_ready", 32'(obs_ready), 32'(0));
            chk("t4_hold_en",    32'(wr_en),     32'(1));
            chk("t4_hold_addr",  32'(wr_addr),   32'(8));
            chk("t4_hold_data",  32'(wr_data),   32'h1000);
        end
        v_wready = 1;
        cycle();
        chk("t4_resume_ready", 32'(obs_ready), 32'b010);
        chk("t4_resume_en",    32'(wr_en),     32'(1));
        chk("t4_resume_src",   32'(wr_src),    32'(1));
        chk("t4_resume_addr",  32'(wr_addr),   32'(9));

        // Locked owner goes idle; requester 0 must keep waiting
        do_reset();
        v_valid[2] = 1; v_lock[2] = 1; v_addr[2] = 4'hC; v_data[2] = 16'hC0C0;
        v_valid[0] = 0; v_addr[0] = 4'h3; v_data[0] = 16'h0303;
        cycle();
        chk("t5_lock_src", 32'(wr_src), 32'(2));
        v_valid[2] = 0; v_valid[0] = 1;
        for (int k = 0; k < 2; k++) begin
            cycle();
            chk("t5_idle_ready", 32'(obs_ready), 32'b100);
            chk("t5_idle_en",    32'(wr_en),     32'(0));
        end
        v_valid[2] = 1; v_lock[2] = 0; v_data[2] = 16'hC1C1;
        cycle();
        chk("t5_final_ready", 32'(obs_ready), 32'b100);
        chk("t5_final_src",   32'(wr_src),    32'(2));
        chk("t5_final_data",  32'(wr_data),   32'hC1C1);
        v_valid[2] = 0;
        cycle();
        chk("t5_next_ready", 32'(obs_ready), 32'b001);
        chk("t5_next_src",   32'(wr_src),    32'(0));

        // Pointer at 2 with only requester 0 valid wraps to 0, pointer -> 1
        do_reset();
        v_valid[1] = 1; v_addr[1] = 4'd2; v_data[1] = 16'h2222;
        cycle();
        v_valid[1] = 0; v_valid[0] = 1; v_addr[0] = 4'd7; v_data[0] = 16'h7777;
        cycle();
        chk("t6_wrap_ready", 32'(obs_ready), 32'b001);
        chk("t6_wrap_src",   32'(wr_src),    32'(0));
        all_valid();
        cycle();
        chk("t6_ptr_src", 32'(wr_src), 32'(1));

        clr();
        rand_cycles(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
